qnigma_chacha20_rx_buf: RTL and testbench

Frame-committing elastic buffer on the output side of qnigma_math_chacha20. The cipher's dat/val/sof/eof output stream has no backpressure; this block captures it and holds each frame until its eof arrives. It then releases whole frames to a downstream consumer that has a ready handshake. Frames that overflow the buffer or violate sof/eof framing are dropped atomically and flagged.

---
 rtl/qnigma_chacha20_pkg.sv | 27 ++
 rtl/qnigma_chacha20_rx_ram.sv | 44 ++++
 rtl/qnigma_chacha20_rx_buf.sv | 214 +++++++++++++++++++++
 tb/tb_qnigma_chacha20_rx_buf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/qnigma_chacha20_pkg.sv
// -----------------------------------------------------------------------------
// qnigma_chacha20_pkg
// Shared types and constants for the ChaCha20 datapath and its output-side
// frame-committing receive buffer.
//   DATA_WIDTH        payload beat width of the cipher stream
//   RX_BUF_DEPTH_DEF  default receive buffer depth in beats
//   rx_buf_state_t    write-side framing state
//   rx_buf_word_t     layout of one stored beat {sof, eof, dat}
// -----------------------------------------------------------------------------
package qnigma_chacha20_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int RX_BUF_DEPTH_DEF = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } rx_buf_state_t;

    typedef struct packed {
        logic                  sof;
        logic                  eof;
        logic [DATA_WIDTH-1:0] dat;
    } rx_buf_word_t;

endpackage

// File: rtl/qnigma_chacha20_rx_ram.sv
// -----------------------------------------------------------------------------
// qnigma_chacha20_rx_ram
// Simple dual-port RAM: one write port, one read port with a registered
// output. The read data register only updates when a read is issued, so it
// holds its value while the consumer stalls.
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable
//   i_raddr  read address
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module qnigma_chacha20_rx_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: storage and read register have no reset so the array maps onto
    // block RAM; nothing downstream consumes the read data until a valid
    // read has been issued.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/qnigma_chacha20_rx_buf.sv
// -----------------------------------------------------------------------------
// qnigma_chacha20_rx_buf
// Frame-committing elastic buffer behind the ChaCha20 core. The cipher stream
// has no backpressure; beats are stored tentatively and become visible to the
// reader only once the frame's eof has been written. Overflowing or malformed
// frames are rolled back atomically.
//   clk    clock
//   rst    asynchronous active-high reset
//   dat_i  cipher output beat          val_i  beat valid (always consumed)
//   sof_i  first beat of frame         eof_i  last beat of frame
//   dat_o  buffered beat               val_o  beat available
//   sof_o  first beat of frame         eof_o  last beat of frame
//   rdy_i  downstream accepts when val_o & rdy_i
//   drp    one-cycle pulse, frame dropped for lack of space
//   err    one-cycle pulse, sof/eof framing violation
//   lvl    committed beats not yet accepted downstream
// -----------------------------------------------------------------------------
module qnigma_chacha20_rx_buf #(
    parameter int DATA_WIDTH = qnigma_chacha20_pkg::DATA_WIDTH,
    parameter int DEPTH      = qnigma_chacha20_pkg::RX_BUF_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    input  logic                     val_i,
    input  logic                     sof_i,
    input  logic                     eof_i,
    output logic [DATA_WIDTH-1:0]    dat_o,
    output logic                     val_o,
    output logic                     sof_o,
    output logic                     eof_o,
    input  logic                     rdy_i,
    output logic                     drp,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   lvl
);

    import qnigma_chacha20_pkg::*;

    localparam int ADDR   = $clog2(DEPTH);
    localparam int PTR_W  = ADDR + 1;
    localparam int WORD_W = DATA_WIDTH + 2;

    // ---------------------------------------------------------------- state
    rx_buf_state_t      r_state;
    logic [PTR_W-1:0]   r_wr_ptr;   // next tentative write slot
    logic [PTR_W-1:0]   r_com_ptr;  // end of the last committed frame
    logic [PTR_W-1:0]   r_rd_ptr;   // oldest beat not yet accepted downstream
    logic [PTR_W-1:0]   r_rf_ptr;   // next beat to fetch from RAM
    logic               r_ram_vld;  // RAM read register holds an unconsumed beat
    logic               r_drp;
    logic               r_err;
    logic               r_val_o;
    logic               r_sof_o;
    logic               r_eof_o;
    logic [DATA_WIDTH-1:0] r_dat_o;

    // ---------------------------------------------------------------- wires
    logic               w_full_wr;
    logic               w_full_com;
    logic               w_we;
    logic [ADDR-1:0]    w_waddr;
    logic [WORD_W-1:0]  w_wdata;
    logic [WORD_W-1:0]  w_rdata;
    logic               w_out_take;
    logic               w_ram_adv;
    logic               w_fetch;
    logic               w_accept;

    // Occupancy is measured against the accepted pointer, so slots whose beats
    // are still in the read pipeline count as used.
    assign w_full_wr  = (r_wr_ptr  - r_rd_ptr) == PTR_W'(DEPTH);
    // A sof beat always restarts at the commit point, so its fullness is
    // judged from there even when a partial frame is being rewound.
    assign w_full_com = (r_com_ptr - r_rd_ptr) == PTR_W'(DEPTH);

    assign w_wdata = {sof_i, eof_i, dat_i};

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_ptr[ADDR-1:0];
        if (val_i) begin
            if (sof_i) begin
                w_we    = !w_full_com;
                w_waddr = r_com_ptr[ADDR-1:0];
            end else if (r_state == FRAME) begin
                w_we    = !w_full_wr;
            end
        end
    end

    // ------------------------------------------------------------ write FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_com_ptr <= '0;
            r_drp     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_drp <= 1'b0;
            r_err <= 1'b0;
            if (val_i) begin
                if (sof_i) begin
                    // A sof anywhere but IDLE abandons the open frame.
                    r_err <= (r_state != IDLE);
                    if (w_full_com) begin
                        r_drp    <= 1'b1;
                        r_wr_ptr <= r_com_ptr;
                        r_state  <= eof_i ? IDLE : DROP;
                    end else if (eof_i) begin
                        r_wr_ptr  <= r_com_ptr + 1'b1;
                        r_com_ptr <= r_com_ptr + 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wr_ptr <= r_com_ptr + 1'b1;
                        r_state  <= FRAME;
                    end
                end else begin
                    case (r_state)
                        IDLE: begin
                            r_err <= 1'b1;
                        end
                        FRAME: begin
                            if (w_full_wr) begin
                                r_drp    <= 1'b1;
                                r_wr_ptr <= r_com_ptr;
                                r_state  <= eof_i ? IDLE : DROP;
                            end else begin
                                r_wr_ptr <= r_wr_ptr + 1'b1;
                                if (eof_i) begin
                                    r_com_ptr <= r_wr_ptr + 1'b1;
                                    r_state   <= IDLE;
                                end
                            end
                        end
                        DROP: begin
                            if (eof_i) begin
                                r_state <= IDLE;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------ read side
    // Two-stage pipeline: RAM read register, then the output register. Each
    // stage refills when empty or when its content moves on, which keeps one
    // beat per cycle flowing and freezes both stages during a stall.
    assign w_accept   = r_val_o && rdy_i;
    assign w_out_take = !r_val_o || rdy_i;
    assign w_ram_adv  = !r_ram_vld || w_out_take;
    assign w_fetch    = w_ram_adv && (r_rf_ptr != r_com_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_rf_ptr  <= '0;
            r_ram_vld <= 1'b0;
            r_val_o   <= 1'b0;
            r_sof_o   <= 1'b0;
            r_eof_o   <= 1'b0;
            r_dat_o   <= '0;
        end else begin
            if (w_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_fetch) begin
                r_rf_ptr  <= r_rf_ptr + 1'b1;
                r_ram_vld <= 1'b1;
            end else if (w_ram_adv) begin
                r_ram_vld <= 1'b0;
            end
            if (w_out_take) begin
                r_val_o <= r_ram_vld;
                if (r_ram_vld) begin
                    {r_sof_o, r_eof_o, r_dat_o} <= w_rdata;
                end
            end
        end
    end

    qnigma_chacha20_rx_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_fetch),
        .i_raddr (r_rf_ptr[ADDR-1:0]),
        .o_rdata (w_rdata)
    );

    // ---------------------------------------------------------------- outputs
    assign dat_o = r_dat_o;
    assign val_o = r_val_o;
    assign sof_o = r_sof_o;
    assign eof_o = r_eof_o;
    assign drp   = r_drp;
    assign err   = r_err;
    assign lvl   = r_com_ptr - r_rd_ptr;

endmodule

// File: tb/tb_qnigma_chacha20_rx_buf.sv
// -----------------------------------------------------------------------------
// tb_qnigma_chacha20_rx_buf
// Scoreboard bench: stimulus pushes expected output beats into a queue, a
// negedge monitor pops and compares every accepted beat and checks that
// stalled outputs hold. Buffer depth is 16 so overflow is reachable.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qnigma_chacha20_rx_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dat_i;
    logic          val_i, sof_i, eof_i, rdy_i;
    logic [DW-1:0] dat_o;
    logic          val_o, sof_o, eof_o, drp, err;
    logic [4:0]    lvl;

    always #5 clk = ~clk;

    qnigma_chacha20_rx_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dat_i (dat_i),
        .val_i (val_i),
        .sof_i (sof_i),
        .eof_i (eof_i),
        .dat_o (dat_o),
        .val_o (val_o),
        .sof_o (sof_o),
        .eof_o (eof_o),
        .rdy_i (rdy_i),
        .drp   (drp),
        .err   (err),
        .lvl   (lvl)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int n_eof    = 0;
    int n_drp    = 0;
    int n_err    = 0;

    logic [DW+1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic          mon_stall = 1'b0;
    logic [DW+1:0] mon_held;

    always @(negedge clk) begin
        if (rst) begin
            mon_stall = 1'b0;
        end else begin
            if (drp) n_drp++;
            if (err) n_err++;
            if (mon_stall)
                check("stall_hold", {val_o, sof_o, eof_o, dat_o}, {1'b1, mon_held});
            if (val_o && rdy_i) begin
                n_beats++;
                if (eof_o) n_eof++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", {sof_o, eof_o, dat_o});
                end else begin
                    check("out_beat", {sof_o, eof_o, dat_o}, exp_q.pop_front());
                end
            end
            mon_stall = val_o && !rdy_i;
            mon_held  = {sof_o, eof_o, dat_o};
        end
    end

    // -------------------------------------------------------------- stimulus
    // Drives one beat for one clock; inputs change 1 ns after the edge.
    task automatic beat(input logic s, input logic e, input logic [DW-1:0] d, input bit keep);
        if (keep) exp_q.push_back({s, e, d});
        val_i = 1'b1; sof_i = s; eof_i = e; dat_i = d;
        @(posedge clk); #1;
        val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && lvl == 0 && !val_o) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check(name, done, 1);
    endtask

    int b0, e0, d0, r0;
    bit seen;

    initial begin
        rst = 1'b0; val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; dat_i = '0; rdy_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("reset_ctrl", {val_o, sof_o, eof_o, drp, err}, 0);
        check("reset_dat",  dat_o, 0);
        check("reset_lvl",  lvl, 0);
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // ---- single 16-beat frame, exact-depth fit into an empty buffer
        for (int i = 0; i < 16; i++) beat(i == 0, i == 15, DW'(i), 1'b1);
        check("t1_lvl_commit", lvl, 16);
        check("t1_val_n0", val_o, 0);
        cycles(1);
        check("t1_val_n1", val_o, 0);
        cycles(1);
        check("t1_val_n2", val_o, 1);
        check("t1_first_sof", {sof_o, dat_o}, {1'b1, 8'h00});
        check("t1_lvl_peak", lvl, 16);
        drain("t1_drain");
        check("t1_lvl_end", lvl, 0);

        // ---- two frames with rdy toggling 1,0,0,1
        b0 = n_beats; e0 = n_eof;
        fork
            begin
                for (int i = 0; i < 5; i++) beat(i == 0, i == 4, 8'h10 + DW'(i), 1'b1);
                for (int i = 0; i < 3; i++) beat(i == 0, i == 2, 8'h20 + DW'(i), 1'b1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    rdy_i = (i % 4 == 0) || (i % 4 == 3);
                    @(posedge clk); #1;
                end
            end
        join
        rdy_i = 1'b1;
        drain("t2_drain");
        check("t2_beats", n_beats - b0, 8);
        check("t2_eofs", n_eof - e0, 2);

        // ---- overflow: 10-beat frame commits, second 10-beat frame dropped
        rdy_i = 1'b0;
        d0 = n_drp; b0 = n_beats;
        for (int i = 0; i < 10; i++) beat(i == 0, i == 9, 8'h30 + DW'(i), 1'b1);
        check("t3_lvl_first", lvl, 10);
        for (int i = 0; i < 10; i++) begin
            beat(i == 0, i == 9, 8'h40 + DW'(i), 1'b0);
            if (i == 5) check("t3_no_drp_16th", drp, 0);
            if (i == 6) check("t3_drp_17th", drp, 1);
        end
        cycles(2);
        check("t3_drp_once", n_drp - d0, 1);
        check("t3_lvl_after", lvl, 10);
        rdy_i = 1'b1;
        drain("t3_drain");
        check("t3_beats", n_beats - b0, 10);

        // ---- framing errors
        r0 = n_err;
        beat(1'b0, 1'b0, 8'h77, 1'b0);
        check("t4_err_idle", err, 1);
        cycles(4);
        check("t4_nothing_stored", {val_o, lvl}, 0);
        check("t4_err_count_a", n_err - r0, 1);
        r0 = n_err;
        beat(1'b1, 1'b0, 8'h50, 1'b0);
        beat(1'b0, 1'b0, 8'h51, 1'b0);
        beat(1'b0, 1'b0, 8'h52, 1'b0);
        beat(1'b1, 1'b0, 8'h60, 1'b1);
        check("t4_err_sof", err, 1);
        beat(1'b0, 1'b0, 8'h61, 1'b1);
        beat(1'b0, 1'b0, 8'h62, 1'b1);
        beat(1'b0, 1'b1, 8'h63, 1'b1);
        drain("t4_drain");
        check("t4_err_count_b", n_err - r0, 1);

        // ---- single-beat frame
        rdy_i = 1'b0;
        beat(1'b1, 1'b1, 8'hA5, 1'b1);
        check("t5_lvl", lvl, 1);
        cycles(3);
        check("t5_out", {val_o, sof_o, eof_o, dat_o}, {3'b111, 8'hA5});
        rdy_i = 1'b1;
        drain("t5_drain");

        // ---- asynchronous reset in the middle of a frame
        rdy_i = 1'b0;
        beat(1'b1, 1'b1, 8'hC3, 1'b0);
        cycles(3);
        for (int i = 0; i < 4; i++) beat(i == 0, 1'b0, 8'h80 + DW'(i), 1'b0);
        check("t6_pre_val", {val_o, lvl}, {1'b1, 5'd1});
        #2 rst = 1'b1;
        #1;
        check("t6_async_ctrl", {val_o, sof_o, eof_o, drp, err}, 0);
        check("t6_async_dat_lvl", {dat_o, lvl}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_i = 1'b1;
        r0 = n_err;
        seen = 1'b0;
        for (int i = 4; i < 8; i++) begin
            beat(1'b0, i == 7, 8'h80 + DW'(i), 1'b0);
            if (val_o) seen = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            if (val_o) seen = 1'b1;
            cycles(1);
        end
        check("t6_err_count", n_err - r0, 4);
        check("t6_no_val", seen, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
